// File: rtl/uart_tx_queue_if.sv
// Write-side and transmitter-side signals of the UART TX byte queue.
// master: CPU/UART side (drives wen, wdata, clr_overflow, tx_ready); slave: the queue.
interface uart_tx_queue_if #(
  parameter int AW = 4
);
  logic          wen;
  logic [7:0]    wdata;
  logic          clr_overflow;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    tx_bus;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output wen, wdata, clr_overflow, tx_ready,
    input  tx_start, tx_bus, full, empty, count, overflow
  );

  modport slave (
    input  wen, wdata, clr_overflow, tx_ready,
    output tx_start, tx_bus, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Circular byte FIFO that feeds a uart_tx start/ready handshake.
// Ports: clk, reset (sync, active-low), bus (slave modport: write side, tx side, status).
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_queue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  state_t        state_q;
  logic          tx_start_q;
  logic [7:0]    tx_bus_q;
  logic          ovf_q;
  logic          ovf_d;

  logic full;
  logic empty;
  logic wr_ok;
  logic drop;
  logic pop;

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    wr_ok = bus.wen && !full;
    drop  = bus.wen && full;
    pop   = (state_q == IDLE) && !empty && bus.tx_ready;

    count_d = count_q;
    if (wr_ok && !pop)
      count_d = count_q + 1'b1;
    else if (!wr_ok && pop)
      count_d = count_q - 1'b1;

    // a dropped write in the same cycle as a clear keeps the flag set
    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (bus.clr_overflow)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset && wr_ok)
      mem_q[wptr_q] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_bus_q   <= 8'h00;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (wr_ok)
        wptr_q <= wptr_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            tx_bus_q   <= mem_q[rptr_q];
            rptr_q     <= rptr_q + 1'b1;
            tx_start_q <= 1'b1;
            state_q    <= WAIT_BUSY;
          end else begin
            tx_start_q <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          // hold start until the transmitter shows it took the byte
          if (!bus.tx_ready) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tx_start_q <= 1'b0;
          if (bus.tx_ready)
            state_q <= IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_bus   = tx_bus_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: expected bytes queued at write,
// checked by a monitor on every tx_start rise.
module tb_uart_tx_queue;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_tx_queue_if #(.AW(4)) bus ();

  uart_tx_queue #(
    .DEPTH(16),
    .AW(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // write one byte (tx_ready held at rd), optionally expecting it to be sent
  task automatic wr(input logic [7:0] b, input logic keep, input logic rd);
    bus.wen = 1'b1;
    bus.wdata = b;
    bus.tx_ready = rd;
    if (keep) exp_q.push_back(b);
    tick();
    bus.wen = 1'b0;
  endtask

  // wait for a started byte, then act as the transmitter for it
  task automatic serve();
    int n;
    n = 0;
    bus.tx_ready = 1'b1;
    while (!bus.tx_start && n < 20) begin
      tick();
      n++;
    end
    if (!bus.tx_start) chk("serve_timeout", 0, 1);
    bus.tx_ready = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
    tick();
  endtask

  // monitor: every new start must carry the oldest expected byte
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset && bus.tx_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          chk("tx_byte", int'(bus.tx_bus), int'(exp_q.pop_front()));
        end
      end
      prev_start = bus.tx_start;
    end
  end

  initial begin
    bus.wen = 1'b0;
    bus.wdata = 8'h00;
    bus.clr_overflow = 1'b0;
    bus.tx_ready = 1'b1;
    tick();
    tick();
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_start", int'(bus.tx_start), 0);
    chk("rst_bus", int'(bus.tx_bus), 0);
    reset = 1'b1;
    tick();

    // single byte latency and handshake
    wr(8'h68, 1'b1, 1'b1);
    chk("s_cnt1", int'(bus.count), 1);
    chk("s_start_lat", int'(bus.tx_start), 0);
    tick();
    chk("s_start", int'(bus.tx_start), 1);
    chk("s_bus", int'(bus.tx_bus), 8'h68);
    chk("s_cnt0", int'(bus.count), 0);
    tick();
    chk("s_hold", int'(bus.tx_start), 1);
    bus.tx_ready = 1'b0;
    tick();
    chk("s_drop", int'(bus.tx_start), 0);
    chk("s_bus_keep", int'(bus.tx_bus), 8'h68);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    chk("s_idle", int'(bus.tx_start), 0);

    // fill, wrap and ordering
    for (int i = 0; i < 16; i++)
      wr(8'(8'h41 + i), 1'b1, 1'b0);
    chk("w_full", int'(bus.full), 1);
    chk("w_cnt16", int'(bus.count), 16);
    for (int i = 0; i < 20; i++) begin
      if (i >= 3 && i < 7)
        wr(8'(8'h51 + i - 3), 1'b1, 1'b0);
      serve();
    end
    chk("w_empty", int'(bus.empty), 1);
    chk("w_cnt0", int'(bus.count), 0);

    // overflow and clear priority
    for (int i = 0; i < 16; i++)
      wr(8'(8'h01 + i), 1'b1, 1'b0);
    wr(8'hFF, 1'b0, 1'b0);
    chk("o_set", int'(bus.overflow), 1);
    chk("o_cnt", int'(bus.count), 16);
    bus.clr_overflow = 1'b1;
    tick();
    chk("o_clr", int'(bus.overflow), 0);
    wr(8'hFF, 1'b0, 1'b0);
    chk("o_setwins", int'(bus.overflow), 1);
    tick();
    bus.clr_overflow = 1'b0;
    chk("o_clr2", int'(bus.overflow), 0);

    // full plus pop: write still dropped
    wr(8'hEE, 1'b0, 1'b1);
    chk("fp_ovf", int'(bus.overflow), 1);
    chk("fp_cnt", int'(bus.count), 15);
    chk("fp_start", int'(bus.tx_start), 1);
    for (int i = 0; i < 16; i++)
      serve();
    chk("fp_empty", int'(bus.empty), 1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;

    // simultaneous write and pop
    wr(8'hA1, 1'b1, 1'b0);
    wr(8'hA2, 1'b1, 1'b0);
    wr(8'hA3, 1'b1, 1'b0);
    wr(8'hA4, 1'b1, 1'b1);
    chk("sim_cnt", int'(bus.count), 3);
    chk("sim_start", int'(bus.tx_start), 1);
    for (int i = 0; i < 4; i++)
      serve();
    chk("sim_empty", int'(bus.empty), 1);

    // reset mid transmission
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      wr(8'(8'hB1 + i), 1'b1, 1'b0);
    bus.tx_ready = 1'b1;
    tick();
    chk("r_cnt5", int'(bus.count), 5);
    chk("r_busy", int'(bus.tx_start), 1);
    reset = 1'b0;
    bus.wen = 1'b1;
    bus.wdata = 8'h77;
    tick();
    exp_q.delete();
    reset = 1'b1;
    bus.wen = 1'b0;
    chk("r_cnt0", int'(bus.count), 0);
    chk("r_start", int'(bus.tx_start), 0);
    chk("r_bus", int'(bus.tx_bus), 0);
    chk("r_empty", int'(bus.empty), 1);
    wr(8'h33, 1'b1, 1'b1);
    serve();
    chk("r_end_empty", int'(bus.empty), 1);
    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
